// File: rtl/spi_flash_reader_if.sv
// Request/response and SPI pin bundle for the serial flash read initiator.
interface spi_flash_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        spi_csb;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;

  // Reader side: accepts requests, drives the flash pins.
  modport slave (
    input  req_valid, req_addr, spi_miso,
    output req_ready, rsp_valid, rsp_data, spi_csb, spi_clk, spi_mosi
  );

  // Requester plus flash side.
  modport master (
    output req_valid, req_addr, spi_miso,
    input  req_ready, rsp_valid, rsp_data, spi_csb, spi_clk, spi_mosi
  );
endinterface

// File: rtl/spi_flash_reader.sv
// Single-lane SPI flash READ (0x03) initiator: 24-bit address in, little-endian 32-bit word out.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_IDLE = 4
) (
  input  logic                clock,
  input  logic                resetb,
  spi_flash_reader_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLast = 8'(CS_IDLE - 1);

  state_e      state_q, state_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [6:0]  bit_q, bit_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  gap_q, gap_d;
  logic        sck_q, sck_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        tick;

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= StIdle;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      gap_q       <= '0;
      sck_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      gap_q       <= gap_d;
      sck_q       <= sck_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next-state logic: SCK divider, shift registers, bit count and CS gap.
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    bit_d       = bit_q;
    div_d       = div_q;
    gap_d       = gap_q;
    sck_d       = sck_q;
    rsp_valid_d = 1'b0;
    tick        = (div_q == DivLast);

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          tx_d    = {8'h03, bus.req_addr};
          bit_d   = '0;
          div_d   = '0;
          sck_d   = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        div_d = tick ? 8'd0 : div_q + 8'd1;
        if (tick) begin
          if (!sck_q) begin
            // Rising SCK: flash has held MISO stable since the previous fall.
            sck_d = 1'b1;
            rx_d  = {rx_q[30:0], bus.spi_miso};
          end else begin
            sck_d = 1'b0;
            tx_d  = {tx_q[30:0], 1'b0};
            bit_d = bit_q + 7'd1;
            if (bit_q == 7'd63) begin
              // Last data bit: first flash byte sits in rx[31:24], move it to [7:0].
              rsp_valid_d = 1'b1;
              rsp_data_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
              gap_d       = GapLast;
              state_d     = StGap;
            end
          end
        end
      end
      StGap: begin
        if (gap_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; chip select and ready decode straight from state so reset acts immediately.
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.spi_csb   = (state_q != StShift);
    bus.spi_clk   = sck_q;
    bus.spi_mosi  = tx_q[31];
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_data  = rsp_data_q;
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench: three readers (CLK_DIV 2, 1, 5) each with a flash model and a timing model.
module tb_spi_flash_reader;

  localparam int CS = 4;
  localparam int NI = 3;

  logic        clock;
  logic        resetb;
  logic        rv;
  logic [23:0] ra;
  int          edge_n = 0;

  int total = 0;
  int bad   = 0;

  // Per-instance observations, each element written only by its own instance block.
  logic        csb_w   [NI];
  logic        sclk_w  [NI];
  logic        mosi_w  [NI];
  logic        ready_w [NI];
  logic        rvld_w  [NI];
  logic [31:0] rdata_w [NI];
  bit          m_active    [NI];
  int          acc_cnt     [NI];
  int          acc_edge    [NI];
  int          dut_rsp_cnt [NI];
  int          rsp_edge    [NI];
  logic [31:0] last_rsp    [NI];
  logic [31:0] cmd_last    [NI];
  int          gap_last    [NI];

  int lat_exp [NI] = '{256, 128, 640};

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) edge_n <= edge_n + 1;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    logic [7:0] r;
    case (a)
      24'h000100: r = 8'h11;
      24'h000101: r = 8'h22;
      24'h000102: r = 8'h33;
      24'h000103: r = 8'h44;
      default:    r = (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] word_at(input logic [23:0] a);
    return {mem_byte(a + 24'd3), mem_byte(a + 24'd2), mem_byte(a + 24'd1), mem_byte(a)};
  endfunction

  task automatic chk(input string name, input int g, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s inst=%0d edge=%0d got=%h want=%h", name, g, edge_n, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int D = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

    spi_flash_reader_if bus();
    assign bus.req_valid = rv;
    assign bus.req_addr  = ra;

    spi_flash_reader #(.CLK_DIV(D), .CS_IDLE(CS)) u_dut (
      .clock  (clock),
      .resetb (resetb),
      .bus    (bus)
    );

    assign csb_w[g]   = bus.spi_csb;
    assign sclk_w[g]  = bus.spi_clk;
    assign mosi_w[g]  = bus.spi_mosi;
    assign ready_w[g] = bus.req_ready;
    assign rvld_w[g]  = bus.rsp_valid;
    assign rdata_w[g] = bus.rsp_data;

    // Flash model: samples MOSI on SCK rise, updates MISO on SCK fall.
    int          fn = 0;
    logic [31:0] fcmd = '0;
    always @(posedge bus.spi_clk or posedge bus.spi_csb) begin
      if (bus.spi_csb) begin
        fn = 0;
      end else begin
        if (fn < 32) fcmd = {fcmd[30:0], bus.spi_mosi};
        fn++;
        if (fn == 32) cmd_last[g] = fcmd;
      end
    end

    always @(negedge bus.spi_clk) begin
      int         b;
      logic [7:0] fb;
      if (!bus.spi_csb && fn >= 32 && fn < 64) begin
        b  = fn - 32;
        fb = mem_byte(fcmd[23:0] + 24'(b / 8));
        bus.spi_miso = fb[7 - (b % 8)];
      end else begin
        bus.spi_miso = 1'b0;
      end
    end

    // Timing model from the accept edge t0: SCK toggles every D clocks, 128 toggles,
    // response right after the last fall, then CS idle cycles.
    initial begin : model
      int          t0, e, off, n, idx, run;
      bit          active;
      logic [23:0] maddr;
      logic [31:0] cmd, exp_data;
      logic        e_rdy, e_csb, e_clk, e_mosi, e_rv;
      active = 0; t0 = 0; maddr = '0; exp_data = '0; run = 0;
      acc_cnt[g] = 0; dut_rsp_cnt[g] = 0; gap_last[g] = 0; m_active[g] = 0;
      forever begin
        @(posedge clock);
        #1;
        e = edge_n;
        if (!resetb) begin
          active   = 0;
          exp_data = '0;
        end else if (active && e == t0 + 128 * D + CS) begin
          active = 0;
        end else if (!active && rv) begin
          active      = 1;
          t0          = e;
          maddr       = ra;
          acc_cnt[g]  = acc_cnt[g] + 1;
          acc_edge[g] = e;
        end
        m_active[g] = active;
        if (active && e == t0 + 128 * D) exp_data = word_at(maddr);
        cmd = {8'h03, maddr};
        e_rdy = 1'b1; e_csb = 1'b1; e_clk = 1'b0; e_mosi = 1'b0; e_rv = 1'b0;
        if (active) begin
          off   = e - t0;
          e_rdy = 1'b0;
          if (off < 128 * D) begin
            n      = off / D;
            idx    = n / 2;
            e_csb  = 1'b0;
            e_clk  = n[0];
            e_mosi = (idx < 32) ? cmd[31 - idx] : 1'b0;
          end else begin
            e_rv = (off == 128 * D);
          end
        end
        chk("req_ready", g, 32'(bus.req_ready), 32'(e_rdy));
        chk("spi_csb",   g, 32'(bus.spi_csb),   32'(e_csb));
        chk("spi_clk",   g, 32'(bus.spi_clk),   32'(e_clk));
        chk("spi_mosi",  g, 32'(bus.spi_mosi),  32'(e_mosi));
        chk("rsp_valid", g, 32'(bus.rsp_valid), 32'(e_rv));
        chk("rsp_data",  g, bus.rsp_data,       exp_data);
        if (bus.rsp_valid) begin
          dut_rsp_cnt[g] = dut_rsp_cnt[g] + 1;
          rsp_edge[g]    = e;
          last_rsp[g]    = bus.rsp_data;
        end
        if (bus.spi_csb) begin
          run++;
        end else begin
          if (run > 0) gap_last[g] = run;
          run = 0;
        end
      end
    end
  end

  task automatic send(input logic [23:0] a);
    @(negedge clock);
    rv = 1'b1;
    ra = a;
    @(negedge clock);
    rv = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((m_active[0] || m_active[1] || m_active[2]) && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("idle_timeout", 0, 32'(k < budget), 32'd1);
  endtask

  task automatic wait_acc(input int target, input int budget);
    int k = 0;
    while (acc_cnt[0] < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("accept_timeout", 0, 32'(k < budget), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog edge=%0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int base [NI];
    int a0;
    resetb = 1'b0;
    rv     = 1'b0;
    ra     = '0;
    repeat (3) @(negedge clock);
    resetb = 1'b1;

    // Idle for 100 clocks after reset.
    repeat (100) @(negedge clock);
    chk("idle_ready", 0, 32'(ready_w[0]), 32'd1);
    chk("idle_csb",   0, 32'(csb_w[0]),   32'd1);
    chk("idle_sclk",  0, 32'(sclk_w[0]),  32'd0);
    chk("idle_data",  0, rdata_w[0],      32'd0);

    // Single read at 0x000100 on all three divisors.
    for (int g = 0; g < NI; g++) base[g] = dut_rsp_cnt[g];
    send(24'h000100);
    wait_idle(1000);
    for (int g = 0; g < NI; g++) begin
      chk("t1_rsp_count", g, 32'(dut_rsp_cnt[g] - base[g]), 32'd1);
      chk("t1_latency",   g, 32'(rsp_edge[g] - acc_edge[g]), 32'(lat_exp[g]));
      chk("t1_data",      g, last_rsp[g], 32'h44332211);
      chk("t1_cmd",       g, cmd_last[g], 32'h03000100);
    end

    // Top-of-memory address.
    send(24'hFFFFFC);
    wait_idle(1000);
    for (int g = 0; g < NI; g++) begin
      chk("t2_latency", g, 32'(rsp_edge[g] - acc_edge[g]), 32'(lat_exp[g]));
      chk("t2_cmd",     g, cmd_last[g], 32'h03FFFFFC);
    end

    // Back-to-back with req_valid held high; address changed while busy.
    base[0] = dut_rsp_cnt[0];
    a0      = acc_cnt[0];
    @(negedge clock);
    rv = 1'b1;
    ra = 24'h000000;
    wait_acc(a0 + 1, 10);
    ra = 24'h000004;
    wait_acc(a0 + 2, 600);
    rv = 1'b0;
    wait_idle(2000);
    chk("b2b_rsp_count", 0, 32'(dut_rsp_cnt[0] - base[0]), 32'd2);
    chk("b2b_cmd",       0, cmd_last[0], 32'h03000004);
    chk("b2b_data",      0, last_rsp[0], 32'h5984E3CE);
    // CS_IDLE gap cycles plus the accept cycle.
    chk("b2b_csb_gap",   0, 32'(gap_last[0]), 32'd5);

    // Random requests while busy must be ignored.
    @(negedge clock);
    rv = 1'b1;
    ra = 24'h000100;
    @(negedge clock);
    for (int i = 0; i < 200; i++) begin
      rv = 1'($urandom_range(0, 1));
      ra = 24'($urandom);
      @(negedge clock);
    end
    rv = 1'b0;
    wait_idle(2000);
    chk("busy_cmd",  0, cmd_last[0], 32'h03000100);
    chk("busy_data", 0, last_rsp[0], 32'h44332211);

    // Reset after 20 SCK cycles of a transfer.
    base[0] = dut_rsp_cnt[0];
    base[2] = dut_rsp_cnt[2];
    send(24'h000100);
    repeat (79) @(negedge clock);
    chk("pre_reset_csb", 0, 32'(csb_w[0]), 32'd0);
    @(posedge clock);
    #3;
    resetb = 1'b0;
    #1;
    for (int g = 0; g < NI; g += 2) begin
      chk("rst_csb",   g, 32'(csb_w[g]),   32'd1);
      chk("rst_sclk",  g, 32'(sclk_w[g]),  32'd0);
      chk("rst_mosi",  g, 32'(mosi_w[g]),  32'd0);
      chk("rst_ready", g, 32'(ready_w[g]), 32'd1);
      chk("rst_rvld",  g, 32'(rvld_w[g]),  32'd0);
    end
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    repeat (300) @(negedge clock);
    chk("abort_no_rsp", 0, 32'(dut_rsp_cnt[0] - base[0]), 32'd0);
    chk("abort_no_rsp", 2, 32'(dut_rsp_cnt[2] - base[2]), 32'd0);
    chk("post_rst_ready", 0, 32'(ready_w[0]), 32'd1);
    send(24'h000100);
    wait_idle(1000);
    chk("post_rst_count", 0, 32'(dut_rsp_cnt[0] - base[0]), 32'd1);
    chk("post_rst_data",  0, last_rsp[0], 32'h44332211);

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
